// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state encoding and bit-period helper
package uart_pkg;
   localparam int DATA_W        = 8;
   localparam int DEF_CLK_FREQ  = 50_000_000;
   localparam int DEF_BAUD_RATE = 115_200;
   localparam int BIT_CYC       = DEF_CLK_FREQ / DEF_BAUD_RATE;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   function automatic int bit_cyc(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling mid-bit, one-cycle valid strobe per good frame
module uart_rx
   import uart_pkg::*;
#(
   parameter int BIT_PERIOD = uart_pkg::BIT_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [DATA_W-1:0] data,
   output logic              valid
);
   localparam int HALF = BIT_PERIOD / 2;
   localparam int CW   = $clog2(BIT_PERIOD);
   localparam int BW   = $clog2(DATA_W);

   uart_state_t       state;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bitn;
   logic [DATA_W-1:0] sh;
   logic              rx_q;
   logic              ferr;
   logic              bit_end;

   assign bit_end = cnt == CW'(BIT_PERIOD - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         bitn  <= '0;
         sh    <= '0;
         rx_q  <= 1'b1;
         ferr  <= 1'b0;
         data  <= '0;
         valid <= 1'b0;
      end else begin
         rx_q  <= rx;
         valid <= 1'b0;
         case (state)
            IDLE:
               if (rx_q && !rx) begin
                  state <= START;
                  cnt   <= '0;
                  bitn  <= '0;
               end
            START:
               if (cnt == CW'(HALF - 1)) begin
                  cnt   <= '0;
                  state <= rx ? IDLE : DATA;
               end else
                  cnt <= cnt + 1'b1;
            DATA:
               if (bit_end) begin
                  cnt   <= '0;
                  sh    <= {rx, sh[DATA_W-1:1]};
                  bitn  <= bitn + 1'b1;
                  state <= bitn == BW'(DATA_W - 1) ? STOP : DATA;
               end else
                  cnt <= cnt + 1'b1;
            STOP:
               // a low stop bit parks here until the line returns high
               if (ferr) begin
                  ferr  <= !rx;
                  state <= rx ? IDLE : STOP;
               end else if (bit_end) begin
                  cnt   <= '0;
                  ferr  <= !rx;
                  valid <= rx;
                  data  <= rx ? sh : data;
                  state <= rx ? IDLE : STOP;
               end else
                  cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: rtl/top_uart_led.sv
// top_uart_led: UART echo -- rx synchronizer, receiver, one-byte holding register, transmitter
module top_uart_led
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = DEF_CLK_FREQ,
   parameter int BAUD_RATE = DEF_BAUD_RATE,
   parameter int STOP_BITS = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic tx
);
   localparam int BC       = bit_cyc(CLK_FREQ, BAUD_RATE);
   localparam int STOP_CYC = STOP_BITS * BC;
   localparam int CW       = $clog2(STOP_CYC);
   localparam int BW       = $clog2(DATA_W);

   logic [1:0]        sync;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic [DATA_W-1:0] hold;
   logic              hold_full;
   logic              load;
   uart_state_t       state;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bitn;
   logic [DATA_W-1:0] sh;
   logic              bit_end;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         sync <= '1;
      else
         sync <= {sync[0], rx};

   uart_rx #(.BIT_PERIOD(BC)) u_rx (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (sync[1]),
      .data (rx_data),
      .valid(rx_valid)
   );

   // a byte arriving in the same cycle as a load refills the slot just vacated
   assign load = state == IDLE && hold_full;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hold_full <= 1'b0;
         hold      <= '0;
      end else begin
         hold_full <= rx_valid || (hold_full && !load);
         if (rx_valid && (!hold_full || load))
            hold <= rx_data;
      end

   assign bit_end = cnt == CW'(BC - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         bitn  <= '0;
         sh    <= '0;
         tx    <= 1'b1;
      end else
         case (state)
            IDLE:
               if (load) begin
                  sh    <= hold;
                  tx    <= 1'b0;
                  cnt   <= '0;
                  bitn  <= '0;
                  state <= START;
               end
            START:
               if (bit_end) begin
                  cnt   <= '0;
                  tx    <= sh[0];
                  state <= DATA;
               end else
                  cnt <= cnt + 1'b1;
            DATA:
               if (bit_end) begin
                  cnt   <= '0;
                  bitn  <= bitn + 1'b1;
                  sh    <= sh >> 1;
                  tx    <= bitn == BW'(DATA_W - 1) ? 1'b1 : sh[1];
                  state <= bitn == BW'(DATA_W - 1) ? STOP : DATA;
               end else
                  cnt <= cnt + 1'b1;
            STOP:
               if (cnt == CW'(STOP_CYC - 1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else
                  cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_top_uart_led.sv
// tb_top_uart_led: scoreboard bench; driver pushes each good rx byte, tx monitor pops and checks
module tb_top_uart_led;
   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 500_000;
   localparam int BC        = CLK_FREQ / BAUD_RATE;
   localparam int HALF      = BC / 2;
   localparam int FRAME     = 11 * BC;
   localparam int B2B_N     = 30;
   // tx frame is 11*BC+1 cycles against 10*BC on rx, so 28 of 30 get echoed
   localparam int B2B_ECHO  = 28;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic       tx;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] sb[$];
   int         toggles = 0;
   int         frames = 0;
   int         b2b_frames = 0;
   bit         b2b = 1'b0;
   time        rx_t, start_t, end_t;
   logic       tx_q = 1'b1;
   logic       mon_on = 1'b0;
   logic       glitch = 1'b0;
   logic [10:0] bits = '0;
   int         mcyc = 0;

   top_uart_led #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .STOP_BITS(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (rx),
      .tx   (tx)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop_ok);
      rx_t = $time;
      if (stop_ok) sb.push_back(b);
      rx = 1'b0;
      repeat (BC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BC) @(negedge clk);
      end
      rx = stop_ok;
      repeat (BC) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(sb.size()), 0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_on = 1'b0;
         tx_q   = 1'b1;
      end else begin
         if (tx !== tx_q) toggles++;
         if (!mon_on && tx_q && !tx) begin
            mon_on  = 1'b1;
            mcyc    = 0;
            glitch  = 1'b0;
            bits    = '0;
            start_t = $time;
            if (b2b && b2b_frames > 0)
               chk("b2b_gap", 32'((start_t - end_t) / 20 <= 3), 1);
         end
         if (mon_on) begin
            if (mcyc % BC == 0) bits[mcyc/BC] = tx;
            else if (tx !== bits[mcyc/BC]) glitch = 1'b1;
            mcyc++;
            if (mcyc == FRAME) begin
               mon_on = 1'b0;
               end_t  = $time;
               frames++;
               if (b2b) b2b_frames++;
               chk("tx_framing", 32'({glitch, bits[0], bits[9], bits[10]}), 32'h3);
               if (sb.size() == 0) chk("tx_unexpected_frame", 32'(sb.size()), 1);
               else chk("echo_byte", 32'(bits[8:1]), 32'(sb.pop_front()));
            end
         end
         tx_q = tx;
      end
   end

   initial begin
      #(2_000_000 * 20);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int f0, t0, lat, budget;
      repeat (5) @(negedge clk);
      chk("reset_tx", 32'(tx), 1);
      rst_n = 1'b1;

      t0 = toggles;
      repeat (1000) @(negedge clk);
      chk("idle_toggles", 32'(toggles - t0), 0);
      chk("idle_tx", 32'(tx), 1);

      f0 = frames;
      send(8'hFA, 1'b1);
      wait_drain("fa_drain");
      lat = int'((start_t - rx_t) / 20);
      chk("echo_latency", 32'(lat >= 9*BC + HALF + 2 && lat <= 9*BC + HALF + 6), 1);
      chk("fa_frames", 32'(frames - f0), 1);

      t0 = toggles;
      rx = 1'b0;
      repeat (30) @(negedge clk);
      rx = 1'b1;
      repeat (2 * FRAME) @(negedge clk);
      chk("false_start_toggles", 32'(toggles - t0), 0);

      f0 = frames;
      send(8'hA5, 1'b0);
      repeat (2 * BC) @(negedge clk);
      send(8'hFF, 1'b1);
      wait_drain("ff_drain");
      repeat (BC) @(negedge clk);
      chk("ferr_frames", 32'(frames - f0), 1);

      b2b = 1'b1;
      b2b_frames = 0;
      for (int i = 0; i < B2B_N; i++) send(8'hFA, 1'b1);
      budget = 0;
      while (b2b_frames < B2B_ECHO && budget < 10 * FRAME) begin
         @(negedge clk);
         budget++;
      end
      repeat (2 * FRAME) @(negedge clk);
      b2b = 1'b0;
      chk("b2b_echoes", 32'(b2b_frames), B2B_ECHO);
      chk("b2b_dropped", 32'(sb.size()), B2B_N - B2B_ECHO);
      sb.delete();

      send(8'h2C, 1'b1);
      rx = 1'b0;
      repeat (BC) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = 8'h5A >> i;
         repeat (BC) @(negedge clk);
      end
      rx = 1'b1;
      repeat (HALF) @(negedge clk);
      chk("tx_low_before_reset", 32'(tx), 0);
      rst_n = 1'b0;
      #1;
      chk("reset_tx_immediate", 32'(tx), 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      f0 = frames;
      t0 = toggles;
      repeat (2 * FRAME) @(negedge clk);
      chk("post_reset_quiet", 32'(toggles - t0), 0);
      send(8'h96, 1'b1);
      wait_drain("post_reset_drain");
      chk("post_reset_frames", 32'(frames - f0), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/top_uart_led.md
TOP_UART_LED -- requirements
Module: top_uart_led

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter STOP_BITS, default 2, number of stop bits transmitted (1 or 2).
REQ-004 Derived constant BIT_CYC = CLK_FREQ/BAUD_RATE, integer-truncated, 434 at defaults (8680 ns bit time).
REQ-005 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 rx  input  1  asynchronous UART receive line; idles high.
REQ-008 tx  output  1  UART transmit line; idles high.

Function
REQ-009 Frame format SHALL be 8 data bits, LSB first, no parity; receiver requires 1 stop bit, transmitter emits STOP_BITS stop bits.
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; glitch filtering beyond this is not required.
REQ-011 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE->START on a synchronized falling edge of rx; the bit counter restarts at 0.
REQ-013 In START, rx is resampled at BIT_CYC/2 (217 cycles); low -> DATA, high -> IDLE (false start, no byte).
REQ-014 In DATA, each bit is sampled every BIT_CYC cycles after the start mid-point; after 8 bits -> STOP.
REQ-015 In STOP, rx is sampled one BIT_CYC later; high -> byte valid (1-cycle internal strobe) and IDLE; low -> framing error, byte discarded, IDLE entered once rx returns high.
REQ-016 Each valid received byte SHALL be echoed unchanged on tx.
REQ-017 Transmitter states SHALL be IDLE, START, DATA, STOP; each bit is held exactly BIT_CYC cycles; STOP lasts STOP_BITS*BIT_CYC cycles.
REQ-018 A one-byte holding register sits between receiver and transmitter: a valid byte is written to it if it is empty, otherwise the byte is dropped (the holding register keeps its older value).
REQ-019 The transmitter loads from the holding register in the cycle after it becomes non-empty while tx is IDLE, clearing it in the same cycle; tx goes low at most 2 cycles after the receive strobe when the transmitter is idle.
REQ-020 Simultaneous receive strobe and holding-register load: the load takes the old byte and the new byte is written, so no byte is lost.
REQ-021 The receiver SHALL run independently of the transmitter and never stall.

Reset
REQ-022 While rst_n is low: tx=1, both FSMs IDLE, all counters 0, holding register empty, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL abort both frames immediately; after release the receiver waits for a fresh falling edge.

Structure
REQ-024 BIT_CYC, the state encodings and the data width (8) SHALL live in a shared package uart_pkg.
REQ-025 The receiver is a single sub-module uart_rx (outputs data[7:0] and valid); the synchronizer, holding register and transmitter are in top_uart_led.

Verification
REQ-026 After reset, rx idle high for 20 us -> tx constant 1, no transitions.
REQ-027 One 0xFA frame at 8680 ns/bit -> tx emits 0, 0,1,0,1,1,1,1,1, 1,1 (start, data LSB first, two stops), each bit 434 cycles.
REQ-028 rx low pulse of 100 cycles -> no byte, tx stays 1.
REQ-029 0xA5 frame with stop bit forced low -> no echo; next valid 0xFF frame -> echoed as 0xFF.
REQ-030 Continuous back-to-back 0xFA frames (1 stop bit) for 30 frames -> every tx frame is 0xFA with 2 stops, no malformed frame, tx never idles more than 2 cycles between frames, excess bytes dropped.
REQ-031 rst_n pulsed low during rx data bit 4 -> tx=1 immediately; the next complete frame is received and echoed correctly.
